fwd_source_tracker: RTL and testbench

- Transmit side of the operand-forwarding interface in the 5-stage MIPS pipeline.
- Tracks the destination register, write enable and remaining-latency count (T_new) of the instructions in E, M and W.
- Drives the per-stage forwarding bundles (Reg_Addr, Reg_Data, T_new, Reg_WriteEn) consumed by the forward-receive muxes.
- Generates the D-stage stall by comparing T_new against the operand T_use.

---
 rtl/fwd_source_tracker_pkg.sv | 25 ++
 rtl/fwd_source_tracker_if.sv | 55 +++++
 rtl/fwd_source_tracker_stage_entry.sv | 57 +++++
 rtl/fwd_source_tracker.sv | 90 +++++++++
 tb/tb_fwd_source_tracker.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_source_tracker_pkg.sv
// fwd_source_tracker_pkg: shared widths, latency constants and entry type for the forwarding tracker.
// Rev 1.0
`default_nettype none
package fwd_source_tracker_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int T_WIDTH    = 3;

  localparam logic [T_WIDTH-1:0] T_USE_NEVER = 3'b111;
  localparam logic [T_WIDTH-1:0] T_NEW_ALU   = 3'd1;
  localparam logic [T_WIDTH-1:0] T_NEW_LOAD  = 3'd2;
  localparam logic [T_WIDTH-1:0] T_NEW_LUI   = 3'd0;
  localparam logic [T_WIDTH-1:0] T_NEW_JAL   = 3'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [T_WIDTH-1:0]    t_new;
  } fwd_entry_t;

  localparam fwd_entry_t BUBBLE_ENTRY = '{addr: '0, we: 1'b0, t_new: '0};

endpackage
`default_nettype wire

// File: rtl/fwd_source_tracker_if.sv
// fwd_source_tracker_if: D-stage request side and per-stage forwarding bundles of the tracker.
// Rev 1.0
`default_nettype none
interface fwd_source_tracker_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int T_WIDTH    = 3
);
  logic [ADDR_WIDTH-1:0] D_Rs_Addr;
  logic [ADDR_WIDTH-1:0] D_Rt_Addr;
  logic [T_WIDTH-1:0]    D_T_use_Rs;
  logic [T_WIDTH-1:0]    D_T_use_Rt;
  logic [ADDR_WIDTH-1:0] D_Reg_Addr;
  logic                  D_Reg_WriteEn;
  logic [T_WIDTH-1:0]    D_T_new;
  logic                  D_Is_MD;
  logic                  E_MD_Busy;
  logic                  Req;
  logic [DATA_WIDTH-1:0] E_Result;
  logic [DATA_WIDTH-1:0] M_Result;
  logic [DATA_WIDTH-1:0] W_Result;

  logic [ADDR_WIDTH-1:0] FWD_E_Reg_Addr;
  logic [ADDR_WIDTH-1:0] FWD_M_Reg_Addr;
  logic [ADDR_WIDTH-1:0] FWD_W_Reg_Addr;
  logic [DATA_WIDTH-1:0] FWD_E_Reg_Data;
  logic [DATA_WIDTH-1:0] FWD_M_Reg_Data;
  logic [DATA_WIDTH-1:0] FWD_W_Reg_Data;
  logic [T_WIDTH-1:0]    FWD_E_T_new;
  logic [T_WIDTH-1:0]    FWD_M_T_new;
  logic [T_WIDTH-1:0]    FWD_W_T_new;
  logic                  FWD_E_Reg_WriteEn;
  logic                  FWD_M_Reg_WriteEn;
  logic                  FWD_W_Reg_WriteEn;
  logic                  Stall;

  modport master (
    output D_Rs_Addr, D_Rt_Addr, D_T_use_Rs, D_T_use_Rt, D_Reg_Addr, D_Reg_WriteEn,
           D_T_new, D_Is_MD, E_MD_Busy, Req, E_Result, M_Result, W_Result,
    input  FWD_E_Reg_Addr, FWD_M_Reg_Addr, FWD_W_Reg_Addr,
           FWD_E_Reg_Data, FWD_M_Reg_Data, FWD_W_Reg_Data,
           FWD_E_T_new, FWD_M_T_new, FWD_W_T_new,
           FWD_E_Reg_WriteEn, FWD_M_Reg_WriteEn, FWD_W_Reg_WriteEn, Stall
  );

  modport slave (
    input  D_Rs_Addr, D_Rt_Addr, D_T_use_Rs, D_T_use_Rt, D_Reg_Addr, D_Reg_WriteEn,
           D_T_new, D_Is_MD, E_MD_Busy, Req, E_Result, M_Result, W_Result,
    output FWD_E_Reg_Addr, FWD_M_Reg_Addr, FWD_W_Reg_Addr,
           FWD_E_Reg_Data, FWD_M_Reg_Data, FWD_W_Reg_Data,
           FWD_E_T_new, FWD_M_T_new, FWD_W_T_new,
           FWD_E_Reg_WriteEn, FWD_M_Reg_WriteEn, FWD_W_Reg_WriteEn, Stall
  );
endinterface
`default_nettype wire

// File: rtl/fwd_source_tracker_stage_entry.sv
// fwd_stage_entry: one registered forwarding entry with clear and optional saturating T_new decrement.
// Rev 1.0
`default_nettype none
module fwd_stage_entry
  import fwd_source_tracker_pkg::*;
#(
  parameter int ADDR_WIDTH = fwd_source_tracker_pkg::ADDR_WIDTH,
  parameter int T_WIDTH    = fwd_source_tracker_pkg::T_WIDTH,
  parameter bit DECREMENT  = 1'b1
) (
  input  wire logic                  clk_i,
  input  wire logic                  reset_i,
  input  wire logic                  clear_i,
  input  wire logic [ADDR_WIDTH-1:0] addr_i,
  input  wire logic                  we_i,
  input  wire logic [T_WIDTH-1:0]    t_new_i,
  output      logic [ADDR_WIDTH-1:0] addr_o,
  output      logic                  we_o,
  output      logic [T_WIDTH-1:0]    t_new_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [T_WIDTH-1:0]    t_new_q, t_new_d;

  always_comb begin
    addr_d  = addr_i;
    we_d    = we_i;
    t_new_d = t_new_i;
    if (DECREMENT && (t_new_i != '0)) begin
      t_new_d = t_new_i - T_WIDTH'(1);
    end
    if (clear_i) begin
      addr_d  = '0;
      we_d    = 1'b0;
      t_new_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      t_new_q <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      t_new_q <= t_new_d;
    end
  end

  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign t_new_o = t_new_q;

endmodule
`default_nettype wire

// File: rtl/fwd_source_tracker.sv
// fwd_source_tracker: E/M/W destination tracking, forwarding bundles and D-stage stall generation.
// Rev 1.0
`default_nettype none
module fwd_source_tracker
  import fwd_source_tracker_pkg::*;
#(
  parameter int ADDR_WIDTH = fwd_source_tracker_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fwd_source_tracker_pkg::DATA_WIDTH,
  parameter int T_WIDTH    = fwd_source_tracker_pkg::T_WIDTH
) (
  input wire logic         clk_i,
  input wire logic         reset_i,
  fwd_source_tracker_if.slave bus
);

  logic [ADDR_WIDTH-1:0] e_addr, m_addr, w_addr;
  logic                  e_we, m_we, w_we;
  logic [T_WIDTH-1:0]    e_t, m_t, w_t;
  logic                  d_we_eff;
  logic                  stall_rs, stall_rt, stall_md, stall;
  logic                  e_clear;

  // $0 is hardwired zero, so a write to it must never be advertised as forwardable.
  assign d_we_eff = bus.D_Reg_WriteEn && (bus.D_Reg_Addr != '0);
  assign e_clear  = bus.Req || stall;

  fwd_stage_entry #(.ADDR_WIDTH(ADDR_WIDTH), .T_WIDTH(T_WIDTH), .DECREMENT(1'b0)) u_entry_e (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (e_clear),
    .addr_i  (bus.D_Reg_Addr),
    .we_i    (d_we_eff),
    .t_new_i (bus.D_T_new),
    .addr_o  (e_addr),
    .we_o    (e_we),
    .t_new_o (e_t)
  );

  fwd_stage_entry #(.ADDR_WIDTH(ADDR_WIDTH), .T_WIDTH(T_WIDTH), .DECREMENT(1'b1)) u_entry_m (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (bus.Req),
    .addr_i  (e_addr),
    .we_i    (e_we),
    .t_new_i (e_t),
    .addr_o  (m_addr),
    .we_o    (m_we),
    .t_new_o (m_t)
  );

  fwd_stage_entry #(.ADDR_WIDTH(ADDR_WIDTH), .T_WIDTH(T_WIDTH), .DECREMENT(1'b1)) u_entry_w (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (bus.Req),
    .addr_i  (m_addr),
    .we_i    (m_we),
    .t_new_i (m_t),
    .addr_o  (w_addr),
    .we_o    (w_we),
    .t_new_o (w_t)
  );

  // W always has T_new == 0 by the time a reader could need it, so only E and M can stall.
  always_comb begin
    stall_rs = (bus.D_Rs_Addr != '0) &&
               ((e_we && (e_addr == bus.D_Rs_Addr) && (e_t > bus.D_T_use_Rs)) ||
                (m_we && (m_addr == bus.D_Rs_Addr) && (m_t > bus.D_T_use_Rs)));
    stall_rt = (bus.D_Rt_Addr != '0) &&
               ((e_we && (e_addr == bus.D_Rt_Addr) && (e_t > bus.D_T_use_Rt)) ||
                (m_we && (m_addr == bus.D_Rt_Addr) && (m_t > bus.D_T_use_Rt)));
    stall_md = bus.D_Is_MD && bus.E_MD_Busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign bus.Stall             = stall;
  assign bus.FWD_E_Reg_Addr    = e_addr;
  assign bus.FWD_M_Reg_Addr    = m_addr;
  assign bus.FWD_W_Reg_Addr    = w_addr;
  assign bus.FWD_E_Reg_WriteEn = e_we;
  assign bus.FWD_M_Reg_WriteEn = m_we;
  assign bus.FWD_W_Reg_WriteEn = w_we;
  assign bus.FWD_E_T_new       = e_t;
  assign bus.FWD_M_T_new       = m_t;
  assign bus.FWD_W_T_new       = w_t;
  assign bus.FWD_E_Reg_Data    = bus.E_Result;
  assign bus.FWD_M_Reg_Data    = bus.M_Result;
  assign bus.FWD_W_Reg_Data    = bus.W_Result;

endmodule
`default_nettype wire

// File: tb/tb_fwd_source_tracker.sv
// tb_fwd_source_tracker: directed and randomized checks of the forwarding tracker against a timing model.
// Rev 1.0
`default_nettype none
module tb_fwd_source_tracker;
  import fwd_source_tracker_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  fwd_source_tracker_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .T_WIDTH(3)) bus ();

  fwd_source_tracker #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .T_WIDTH(3)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // Model: each stage holds an instruction with the absolute cycle its result becomes ready.
  bit       mv[3];
  bit       mw[3];
  bit [4:0] ma[3];
  int       mr[3];
  int       cyc = 0;

  function automatic bit [2:0] m_tnew(int s);
    if (!mv[s] || mr[s] <= cyc) return 3'd0;
    return 3'(mr[s] - cyc);
  endfunction

  function automatic bit m_wen(int s);
    return mv[s] && mw[s];
  endfunction

  function automatic bit [4:0] m_addr(int s);
    return mv[s] ? ma[s] : 5'd0;
  endfunction

  function automatic bit m_needs_wait(bit [4:0] r, bit [2:0] t_use);
    bit w = 1'b0;
    if (r == 5'd0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (m_wen(s) && ma[s] == r && m_tnew(s) > t_use) w = 1'b1;
    return w;
  endfunction

  function automatic bit m_stall();
    return m_needs_wait(bus.D_Rs_Addr, bus.D_T_use_Rs) ||
           m_needs_wait(bus.D_Rt_Addr, bus.D_T_use_Rt) ||
           (bus.D_Is_MD && bus.E_MD_Busy);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin mv[s] = 0; mw[s] = 0; ma[s] = 0; mr[s] = 0; end
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    if (bus.Req) begin
      model_reset();
    end else begin
      mv[2] = mv[1]; mw[2] = mw[1]; ma[2] = ma[1]; mr[2] = mr[1];
      mv[1] = mv[0]; mw[1] = mw[0]; ma[1] = ma[0]; mr[1] = mr[0];
      mv[0] = !st;
      ma[0] = bus.D_Reg_Addr;
      mw[0] = bus.D_Reg_WriteEn && (bus.D_Reg_Addr != 5'd0);
      mr[0] = cyc + 1 + int'(bus.D_T_new);
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.D_Rs_Addr = 0; bus.D_Rt_Addr = 0;
    bus.D_T_use_Rs = T_USE_NEVER; bus.D_T_use_Rt = T_USE_NEVER;
    bus.D_Reg_Addr = 0; bus.D_Reg_WriteEn = 0; bus.D_T_new = 0;
    bus.D_Is_MD = 0; bus.E_MD_Busy = 0; bus.Req = 0;
  endtask

  task automatic issue(bit [4:0] dst, bit we, bit [2:0] tn, bit [4:0] rs, bit [2:0] urs,
                       bit [4:0] rt, bit [2:0] urt);
    bus.D_Reg_Addr = dst; bus.D_Reg_WriteEn = we; bus.D_T_new = tn;
    bus.D_Rs_Addr = rs; bus.D_T_use_Rs = urs; bus.D_Rt_Addr = rt; bus.D_T_use_Rt = urt;
  endtask

  task automatic test_reset();
    issue(5'd3, 1'b1, T_NEW_LOAD, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    repeat (3) tick();
    issue(5'd3, 1'b1, T_NEW_LOAD, 5'd3, 3'd0, 5'd0, T_USE_NEVER);
    #1;
    checks++;
    if (bus.Stall !== 1'b1) begin errors++; $display("FAIL reset_pre_stall: got %b want 1", bus.Stall); end
    #1 reset_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({bus.FWD_E_Reg_Addr, bus.FWD_M_Reg_Addr, bus.FWD_W_Reg_Addr,
         bus.FWD_E_T_new, bus.FWD_M_T_new, bus.FWD_W_T_new,
         bus.FWD_E_Reg_WriteEn, bus.FWD_M_Reg_WriteEn, bus.FWD_W_Reg_WriteEn} !== '0) begin
      errors++;
      $display("FAIL reset_entries: E=%0d/%b/%0d M=%0d/%b/%0d W=%0d/%b/%0d want all 0",
               bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_WriteEn, bus.FWD_E_T_new,
               bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_WriteEn, bus.FWD_M_T_new,
               bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_WriteEn, bus.FWD_W_T_new);
    end
    checks++;
    if (bus.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.Stall); end
    #1 reset_i = 1'b0;
    idle();
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_use();
    issue(5'd8, 1'b1, T_NEW_LOAD, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    tick();
    issue(5'd10, 1'b1, T_NEW_ALU, 5'd8, 3'd1, 5'd0, T_USE_NEVER);
    #1;
    checks++;
    if (bus.Stall !== 1'b1) begin errors++; $display("FAIL lw_use_stall: got %b want 1", bus.Stall); end
    tick();
    checks++;
    if (bus.FWD_M_Reg_Addr !== 5'd8 || bus.FWD_M_T_new !== 3'd1 || bus.FWD_E_Reg_WriteEn !== 1'b0) begin
      errors++;
      $display("FAIL lw_use_bubble: M_addr=%0d M_t=%0d E_we=%b want 8 1 0",
               bus.FWD_M_Reg_Addr, bus.FWD_M_T_new, bus.FWD_E_Reg_WriteEn);
    end
    checks++;
    if (bus.Stall !== 1'b0) begin errors++; $display("FAIL lw_use_release: got %b want 0", bus.Stall); end
    tick();
    checks++;
    if (bus.FWD_W_T_new !== 3'd0 || bus.FWD_W_Reg_Addr !== 5'd8 || bus.Stall !== 1'b0 ||
        bus.FWD_E_Reg_Addr !== 5'd10 || bus.FWD_E_T_new !== 3'd1) begin
      errors++;
      $display("FAIL lw_use_w: W_t=%0d W_addr=%0d stall=%b E_addr=%0d E_t=%0d want 0 8 0 10 1",
               bus.FWD_W_T_new, bus.FWD_W_Reg_Addr, bus.Stall, bus.FWD_E_Reg_Addr, bus.FWD_E_T_new);
    end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_alu_branch();
    issue(5'd9, 1'b1, T_NEW_ALU, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    tick();
    issue(5'd0, 1'b0, T_NEW_LUI, 5'd9, 3'd0, 5'd9, 3'd0);
    bus.M_Result = 32'hCAFE_0009;
    #1;
    checks++;
    if (bus.Stall !== 1'b1 || bus.FWD_E_T_new !== 3'd1) begin
      errors++; $display("FAIL alu_branch_stall: stall=%b E_t=%0d want 1 1", bus.Stall, bus.FWD_E_T_new);
    end
    tick();
    checks++;
    if (bus.FWD_M_T_new !== 3'd0 || bus.FWD_M_Reg_Data !== 32'hCAFE_0009 || bus.Stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_branch_fwd: M_t=%0d M_data=%h stall=%b want 0 cafe0009 0",
               bus.FWD_M_T_new, bus.FWD_M_Reg_Data, bus.Stall);
    end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_zero_reg();
    issue(5'd0, 1'b1, T_NEW_LOAD, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    tick();
    checks++;
    if (bus.FWD_E_Reg_WriteEn !== 1'b0) begin
      errors++; $display("FAIL zero_reg_we: got %b want 0", bus.FWD_E_Reg_WriteEn);
    end
    issue(5'd4, 1'b1, T_NEW_ALU, 5'd0, 3'd0, 5'd0, 3'd0);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall: got %b want 0", bus.Stall); end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_req();
    issue(5'd11, 1'b1, T_NEW_ALU, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    tick();
    issue(5'd12, 1'b1, T_NEW_LOAD, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    tick();
    issue(5'd13, 1'b1, T_NEW_ALU, 5'd12, 3'd0, 5'd11, 3'd1);
    bus.Req = 1'b1;
    #1;
    checks++;
    if (bus.Stall !== 1'b1 || bus.FWD_E_Reg_Addr !== 5'd12 || bus.FWD_M_Reg_Addr !== 5'd11) begin
      errors++;
      $display("FAIL req_setup: stall=%b E=%0d M=%0d want 1 12 11", bus.Stall, bus.FWD_E_Reg_Addr, bus.FWD_M_Reg_Addr);
    end
    tick();
    checks++;
    if ({bus.FWD_E_Reg_Addr, bus.FWD_M_Reg_Addr, bus.FWD_W_Reg_Addr,
         bus.FWD_E_T_new, bus.FWD_M_T_new, bus.FWD_W_T_new,
         bus.FWD_E_Reg_WriteEn, bus.FWD_M_Reg_WriteEn, bus.FWD_W_Reg_WriteEn} !== '0) begin
      errors++;
      $display("FAIL req_flush: E=%0d/%b M=%0d/%b W=%0d/%b want bubbles", bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_WriteEn,
               bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_WriteEn, bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_WriteEn);
    end
    idle();
    tick();
  endtask

  task automatic test_md_busy();
    issue(5'd6, 1'b1, T_NEW_ALU, 5'd0, T_USE_NEVER, 5'd0, T_USE_NEVER);
    bus.D_Is_MD = 1'b1;
    bus.E_MD_Busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin errors++; $display("FAIL md_stall[%0d]: got %b want 1", i, bus.Stall); end
      tick();
      checks++;
      if (bus.FWD_E_Reg_Addr !== 5'd0 || bus.FWD_E_Reg_WriteEn !== 1'b0 || bus.FWD_E_T_new !== 3'd0) begin
        errors++;
        $display("FAIL md_bubble[%0d]: E=%0d/%b/%0d want 0/0/0", i, bus.FWD_E_Reg_Addr,
                 bus.FWD_E_Reg_WriteEn, bus.FWD_E_T_new);
      end
    end
    bus.E_MD_Busy = 1'b0;
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin errors++; $display("FAIL md_release: got %b want 0", bus.Stall); end
    tick();
    checks++;
    if (bus.FWD_E_Reg_Addr !== 5'd6 || bus.FWD_E_Reg_WriteEn !== 1'b1) begin
      errors++; $display("FAIL md_issue: E=%0d/%b want 6/1", bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_WriteEn);
    end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.D_Rs_Addr     = 5'($urandom_range(0, 3));
      bus.D_Rt_Addr     = 5'($urandom_range(0, 3));
      bus.D_T_use_Rs    = ($urandom_range(0, 4) == 0) ? T_USE_NEVER : 3'($urandom_range(0, 2));
      bus.D_T_use_Rt    = ($urandom_range(0, 4) == 0) ? T_USE_NEVER : 3'($urandom_range(0, 2));
      bus.D_Reg_Addr    = 5'($urandom_range(0, 3));
      bus.D_Reg_WriteEn = 1'($urandom_range(0, 1));
      bus.D_T_new       = 3'($urandom_range(0, 3));
      bus.D_Is_MD       = ($urandom_range(0, 3) == 0);
      bus.E_MD_Busy     = 1'($urandom_range(0, 1));
      bus.Req           = ($urandom_range(0, 14) == 0);
      bus.E_Result      = $urandom;
      bus.M_Result      = $urandom;
      bus.W_Result      = $urandom;
      #1;
      checks++;
      if (bus.Stall !== m_stall()) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, bus.Stall, m_stall());
      end
      checks++;
      if ({bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_WriteEn, bus.FWD_E_T_new} !== {m_addr(0), m_wen(0), m_tnew(0)}) begin
        errors++;
        $display("FAIL rnd_E[%0d]: got %0d/%b/%0d want %0d/%b/%0d", i, bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_WriteEn,
                 bus.FWD_E_T_new, m_addr(0), m_wen(0), m_tnew(0));
      end
      checks++;
      if ({bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_WriteEn, bus.FWD_M_T_new} !== {m_addr(1), m_wen(1), m_tnew(1)}) begin
        errors++;
        $display("FAIL rnd_M[%0d]: got %0d/%b/%0d want %0d/%b/%0d", i, bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_WriteEn,
                 bus.FWD_M_T_new, m_addr(1), m_wen(1), m_tnew(1));
      end
      checks++;
      if ({bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_WriteEn, bus.FWD_W_T_new} !== {m_addr(2), m_wen(2), m_tnew(2)}) begin
        errors++;
        $display("FAIL rnd_W[%0d]: got %0d/%b/%0d want %0d/%b/%0d", i, bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_WriteEn,
                 bus.FWD_W_T_new, m_addr(2), m_wen(2), m_tnew(2));
      end
      checks++;
      if ({bus.FWD_E_Reg_Data, bus.FWD_M_Reg_Data, bus.FWD_W_Reg_Data} !==
          {bus.E_Result, bus.M_Result, bus.W_Result}) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got %h %h %h want %h %h %h", i, bus.FWD_E_Reg_Data, bus.FWD_M_Reg_Data,
                 bus.FWD_W_Reg_Data, bus.E_Result, bus.M_Result, bus.W_Result);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    bus.E_Result = 32'h1111_1111;
    bus.M_Result = 32'h2222_2222;
    bus.W_Result = 32'h3333_3333;
    model_reset();
    #12 reset_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_zero_reg();
    test_req();
    test_md_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
